// File: rtl/dm_cache_refill.sv
// dm_cache_refill: direct-mapped read cache with a line-refill engine.
// A request is latched in IDLE and its tag/word are read into registers,
// which makes COMPARE the hit cycle. On a miss the whole line is fetched
// as a burst, installed, and the requested word is returned from the
// captured beat.
// Optional feature: define DM_CACHE_STATS_EN to add saturating
// hit_count / miss_count outputs.
module dm_cache_refill #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int INDEX_W        = 8,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              flush,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [DATA_W-1:0] resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DM_CACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int OFF_W  = $clog2(WORDS_PER_LINE);
   localparam int BYTE_W = $clog2(DATA_W / 8);
   localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W - BYTE_W;
   localparam int LINES  = 1 << INDEX_W;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      MISS_REQ,
      REFILL,
      RESP
   } state_t;

   state_t state_reg, state_next;

   // Request address fields
   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_index;
   logic [OFF_W-1:0]   req_off;
   logic               unused_addr_bits;

   assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
   assign req_index = req_addr[BYTE_W+OFF_W +: INDEX_W];
   assign req_off   = req_addr[BYTE_W +: OFF_W];
   // Byte-offset bits are intentionally not decoded
   assign unused_addr_bits = ^req_addr;

   // Latched request and refill bookkeeping
   logic [TAG_W-1:0]   tag_reg;
   logic [INDEX_W-1:0] index_reg;
   logic [OFF_W-1:0]   off_reg;
   logic [OFF_W-1:0]   cnt_reg;
   logic [DATA_W-1:0]  beat_word_reg;
   logic [DATA_W-1:0]  resp_data_hold_reg;
   logic               resp_hit_hold_reg;

   // Storage: valid flops, tag and data arrays (registered read)
   logic               valid_reg [LINES];
   logic [TAG_W-1:0]   tag_mem [LINES];
   logic [DATA_W-1:0]  data_mem [LINES*WORDS_PER_LINE];
   logic [TAG_W-1:0]   rd_tag_reg;
   logic [DATA_W-1:0]  rd_word_reg;

   // Control strobes from the FSM
   logic accept;
   logic flush_all;
   logic refill_we;
   logic last_beat;
   logic lookup_hit;

   assign lookup_hit = valid_reg[index_reg] && (rd_tag_reg == tag_reg);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state and output decode
   always_comb begin
      state_next    = state_reg;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_hit      = resp_hit_hold_reg;
      resp_data     = resp_data_hold_reg;
      mem_req_valid = 1'b0;
      mem_addr      = '0;
      accept        = 1'b0;
      flush_all     = 1'b0;
      refill_we     = 1'b0;
      last_beat     = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (flush) begin
               flush_all = 1'b1;
            end else if (req_valid) begin
               accept     = 1'b1;
               state_next = COMPARE;
            end
         end
         COMPARE: begin
            if (lookup_hit) begin
               resp_valid = 1'b1;
               resp_hit   = 1'b1;
               resp_data  = rd_word_reg;
               state_next = IDLE;
            end else begin
               state_next = MISS_REQ;
            end
         end
         MISS_REQ: begin
            mem_req_valid = 1'b1;
            mem_addr      = {tag_reg, index_reg, {(OFF_W+BYTE_W){1'b0}}};
            if (mem_req_ready) state_next = REFILL;
         end
         REFILL: begin
            if (mem_rvalid) begin
               refill_we = 1'b1;
               if (cnt_reg == LAST_BEAT) begin
                  last_beat  = 1'b1;
                  state_next = RESP;
               end
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_hit   = 1'b0;
            resp_data  = beat_word_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch, beat counter and requested-word capture
   always_ff @(posedge clk) begin
      if (accept) begin
         tag_reg   <= req_tag;
         index_reg <= req_index;
         off_reg   <= req_off;
      end
      if (state_reg == MISS_REQ)
         cnt_reg <= '0;
      else if (refill_we)
         cnt_reg <= cnt_reg + OFF_W'(1);
      if (refill_we && (cnt_reg == off_reg))
         beat_word_reg <= mem_rdata;
   end

   // Response hold registers keep data/hit stable between pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_data_hold_reg <= '0;
         resp_hit_hold_reg  <= 1'b0;
      end else if (resp_valid) begin
         resp_data_hold_reg <= resp_data;
         resp_hit_hold_reg  <= resp_hit;
      end
   end

   // Data array: refill writes, lookup read on acceptance
   always_ff @(posedge clk) begin
      if (refill_we && !rst)
         data_mem[{index_reg, cnt_reg}] <= mem_rdata;
      if (accept)
         rd_word_reg <= data_mem[{req_index, req_off}];
   end

   // Tag array: installed on the final beat, read on acceptance
   always_ff @(posedge clk) begin
      if (last_beat && !rst)
         tag_mem[index_reg] <= tag_reg;
      if (accept)
         rd_tag_reg <= tag_mem[req_index];
   end

   // Per-line valid bits: reset/flush clear all, final beat sets one
   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk) begin
            if (rst || flush_all)
               valid_reg[gi] <= 1'b0;
            else if (last_beat && (index_reg == INDEX_W'(gi)))
               valid_reg[gi] <= 1'b1;
         end
      end
   endgenerate

`ifdef DM_CACHE_STATS_EN
   logic [31:0] hit_count_reg;
   logic [31:0] miss_count_reg;

   // Saturating hit/miss counters, untouched by flush
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else if (state_reg == COMPARE) begin
         if (lookup_hit) begin
            if (hit_count_reg != '1) hit_count_reg <= hit_count_reg + 32'd1;
         end else begin
            if (miss_count_reg != '1) miss_count_reg <= miss_count_reg + 32'd1;
         end
      end
   end

   assign hit_count  = hit_count_reg;
   assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_dm_cache_refill.sv
// Directed testbench for dm_cache_refill (default parameters).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_dm_cache_refill;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_addr;
   logic        flush;
   logic        resp_valid;
   logic        resp_hit;
   logic [31:0] resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [15:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
`ifdef DM_CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int total = 0;
   int bad   = 0;

   dm_cache_refill dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .flush         (flush),
      .resp_valid    (resp_valid),
      .resp_hit      (resp_hit),
      .resp_data     (resp_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata)
`ifdef DM_CACHE_STATS_EN
      ,
      .hit_count     (hit_count),
      .miss_count    (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; the DUT must be ready to take it
   task automatic start_read(input logic [15:0] a);
      req_addr  = a;
      req_valid = 1'b1;
      check("accept_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      $display("read 0x%04h accepted", a);
   endtask

   // Called in the cycle after acceptance
   task automatic expect_hit(input logic [31:0] word);
      check("hit_valid", resp_valid, 1);
      check("hit_flag", resp_hit, 1);
      check("hit_data", resp_data, word);
      check("hit_no_memreq", mem_req_valid, 0);
      @(negedge clk);
      check("hit_pulse_end", resp_valid, 0);
      check("hit_data_held", resp_data, word);
      check("hit_back_idle", req_ready, 1);
      $display("hit response data=0x%0h", word);
   endtask

   // Called in the cycle after acceptance; serves the line burst
   task automatic expect_miss(input logic [15:0] line_addr, input logic [31:0] base,
                              input int stall, input logic [31:0] word);
      check("miss_no_resp", resp_valid, 0);
      @(negedge clk);
      check("memreq_valid", mem_req_valid, 1);
      check("memreq_addr", mem_addr, line_addr);
      check("memreq_busy", req_ready, 0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_valid", mem_req_valid, 1);
         check("stall_addr", mem_addr, line_addr);
         check("stall_busy", req_ready, 0);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check("refill_memreq_low", mem_req_valid, 0);
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = base + 32'(i);
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (i == 3) break;
         check("refill_no_resp", resp_valid, 0);
      end
      check("miss_resp_valid", resp_valid, 1);
      check("miss_resp_hit", resp_hit, 0);
      check("miss_resp_data", resp_data, word);
      @(negedge clk);
      check("miss_pulse_end", resp_valid, 0);
      check("miss_back_idle", req_ready, 1);
      $display("miss line 0x%04h response data=0x%0h", line_addr, word);
   endtask

   initial begin
      rst           = 1'b1;
      req_valid     = 1'b0;
      req_addr      = '0;
      flush         = 1'b0;
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_hit", resp_hit, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_mem_addr", mem_addr, 0);
      rst = 1'b0;
      @(negedge clk);
      $display("reset checked");

      // Cold miss
      start_read(16'h1234);
      expect_miss(16'h1230, 32'hA0, 0, 32'hA1);
      // Hit after refill
      start_read(16'h1238);
      expect_hit(32'hA2);
      // Conflict on index 0x23
      start_read(16'h2234);
      expect_miss(16'h2230, 32'hB0, 0, 32'hB1);
      // Evicted line misses again, with a 5-cycle fetch stall
      start_read(16'h1234);
      expect_miss(16'h1230, 32'hA0, 5, 32'hA1);
`ifdef DM_CACHE_STATS_EN
      check("stats_hit", hit_count, 1);
      check("stats_miss", miss_count, 3);
`endif
      // Line boundaries: offsets 0 and 3
      start_read(16'h1230);
      expect_hit(32'hA0);
      start_read(16'h123C);
      expect_hit(32'hA3);

      // flush and request together: request dropped, lines invalidated
      flush     = 1'b1;
      req_valid = 1'b1;
      req_addr  = 16'h1238;
      @(negedge clk);
      flush     = 1'b0;
      req_valid = 1'b0;
      check("flush_not_accepted", req_ready, 1);
      check("flush_no_resp", resp_valid, 0);
      @(negedge clk);
      check("flush_no_memreq", mem_req_valid, 0);
      check("flush_still_idle", req_ready, 1);
      $display("flush with request issued");
      start_read(16'h1238);
      expect_miss(16'h1230, 32'hC0, 0, 32'hC2);

      // Reset after 2 of 4 beats
      start_read(16'h3234);
      check("mr_compare_no_resp", resp_valid, 0);
      @(negedge clk);
      check("mr_memreq_addr", mem_addr, 16'h3230);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hD0 + 32'(i);
         @(negedge clk);
      end
      rst       = 1'b1;
      mem_rdata = 32'hD2;
      @(negedge clk);
      rst       = 1'b0;
      mem_rdata = 32'hD3;
      check("mr_no_resp", resp_valid, 0);
      check("mr_idle_ready", req_ready, 1);
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("mr_stray_no_resp", resp_valid, 0);
      check("mr_stray_no_memreq", mem_req_valid, 0);
      check("mr_stray_ready", req_ready, 1);
      $display("reset mid-refill issued");
      start_read(16'h3234);
      expect_miss(16'h3230, 32'hE0, 0, 32'hE1);
      start_read(16'h323C);
      expect_hit(32'hE3);
      // Reset also invalidated the previously cached 0x1230 line
      start_read(16'h1234);
      expect_miss(16'h1230, 32'hF0, 0, 32'hF1);
`ifdef DM_CACHE_STATS_EN
      check("stats_hit_after_rst", hit_count, 1);
      check("stats_miss_after_rst", miss_count, 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
